dmx_frame_buffer: RTL

- Frame-level controller between the DMX receiver's write-strobe output and the LED matrix scanner.
- Sequences a double-buffered channel store. Captures one complete DMX frame into the back bank, then swaps banks only on the display's frame boundary, so the scanner never shows a torn frame.
- Detects loss of DMX signal and optionally blanks the output.

---
 rtl/dmx_frame_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmx_frame_buffer.sv
// Double-buffered DMX channel store: captures one full frame into the back bank and swaps
// banks only on the scanner's vsync, with signal-loss detection and optional blanking.
module dmx_frame_buffer #(
    parameter int unsigned DMX_CHANNELS  = 8,
    parameter int unsigned TIMEOUT_COUNT = 48000000,
    parameter bit          BLANK_ON_LOSS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  wr_address,
    input  logic [7:0]  wr_data,
    input  logic        write_strobe,
    input  logic        vsync,
    input  logic [8:0]  rd_address,
    output logic [7:0]  rd_data,
    output logic        frame_valid,
    output logic        signal_lost,
    output logic        swapped,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam int unsigned IdxW = (DMX_CHANNELS > 1) ? $clog2(DMX_CHANNELS) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_COUNT + 1);

    localparam logic [8:0]      LastAddr    = 9'(DMX_CHANNELS - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_COUNT - 1);
    localparam logic [CntW-1:0] TimeoutMax  = CntW'(TIMEOUT_COUNT);

    localparam logic [1:0] StWaitStart = 2'd0;
    localparam logic [1:0] StReceiving = 2'd1;
    localparam logic [1:0] StReady     = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            front_q, front_d;
    logic            frame_valid_q, frame_valid_d;
    logic            signal_lost_q, signal_lost_d;
    logic            swapped_q, swapped_d;
    logic            overrun_q, overrun_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [CntW-1:0] idle_q, idle_d;
    logic [7:0]      rd_data_q;

    logic            bank_we;
    logic            in_range;
    logic            addr_zero;
    logic            loss_event;

    logic [7:0] bank_mem [2][DMX_CHANNELS];

    always_comb begin
        state_d       = state_q;
        front_d       = front_q;
        frame_valid_d = frame_valid_q;
        signal_lost_d = signal_lost_q;
        frame_count_d = frame_count_q;
        idle_d        = idle_q;
        swapped_d     = 1'b0;
        overrun_d     = 1'b0;
        bank_we       = 1'b0;

        in_range   = (wr_address <= LastAddr);
        addr_zero  = (wr_address == 9'd0);
        loss_event = !write_strobe && (idle_q == TimeoutLast);

        if (write_strobe) begin
            idle_d        = '0;
            signal_lost_d = 1'b0;
        end else if (idle_q != TimeoutMax) begin
            idle_d = idle_q + 1'b1;
        end

        // A partial frame is abandoned on loss; a complete pending frame may still swap.
        if (loss_event) begin
            signal_lost_d = 1'b1;
            if (state_q == StReceiving) begin
                state_d = StWaitStart;
            end
            if (BLANK_ON_LOSS) begin
                frame_valid_d = 1'b0;
            end
        end

        case (state_q)
            StWaitStart: begin
                if (write_strobe && addr_zero) begin
                    bank_we = 1'b1;
                    state_d = (DMX_CHANNELS == 1) ? StReady : StReceiving;
                end
            end
            StReceiving: begin
                if (write_strobe && in_range) begin
                    bank_we = 1'b1;
                    if (wr_address == LastAddr) begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                overrun_d = write_strobe && addr_zero;
                if (vsync) begin
                    front_d       = ~front_q;
                    frame_valid_d = 1'b1;
                    swapped_d     = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = StWaitStart;
                end
            end
            default: state_d = StWaitStart;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StWaitStart;
            front_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            signal_lost_q <= 1'b1;
            swapped_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
            idle_q        <= '0;
            rd_data_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            front_q       <= front_d;
            frame_valid_q <= frame_valid_d;
            signal_lost_q <= signal_lost_d;
            swapped_q     <= swapped_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            idle_q        <= idle_d;
            // Uses the pre-swap front, so a read on the swap cycle sees the old bank.
            if ((rd_address <= LastAddr) && frame_valid_q) begin
                rd_data_q <= bank_mem[front_q][rd_address[IdxW-1:0]];
            end else begin
                rd_data_q <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bank_we && !rst) begin
            bank_mem[~front_q][wr_address[IdxW-1:0]] <= wr_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign signal_lost = signal_lost_q;
    assign swapped     = swapped_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule
